// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache refill/writeback interface: a word-addressed RAM
// that applies writes on accept and returns reads as 1-beat words or 4-beat lines.
// Optional define STALL_INJECT_EN adds LFSR-driven beat stalls and ready drops.
module cache_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [1:0]   ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    localparam logic [15:0] RD_CNT_INIT = 16'((RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0);
    localparam logic [15:0] WR_CNT_INIT = 16'((WR_LATENCY >= 1) ? WR_LATENCY - 1 : 0);
    localparam logic [2:0]  TYPE_LINE   = 3'b100;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic {W_IDLE, W_BUSY} w_state_t;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    r_state_t              r_state, r_next;
    w_state_t              w_state, w_next;
    logic [15:0]           r_cnt, r_cnt_next;
    logic [15:0]           w_cnt, w_cnt_next;
    logic [ADDR_WIDTH-1:0] rd_base, rd_base_next;
    logic [1:0]            beat, beat_next;
    logic [1:0]            last_beat, last_beat_next;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_accept, wr_accept;
    logic                  beat_stall, rdy_stall;

`ifdef STALL_INJECT_EN
    logic [15:0] lfsr;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, advancing every cycle
    always_ff @(posedge clk) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign beat_stall = lfsr[0];
    assign rdy_stall  = lfsr[1];
`else
    assign beat_stall = 1'b0;
    assign rdy_stall  = 1'b0;
`endif

    // Outputs are gated by reset so they read idle during the very first reset cycle
    assign rd_rdy    = (r_state == R_IDLE) && !reset && !rdy_stall;
    assign wr_rdy    = (w_state == W_IDLE) && !reset && !rdy_stall;
    assign rd_accept = rd_req && rd_rdy;
    assign wr_accept = wr_req && wr_rdy;

    assign ret_valid = (r_state == R_DATA) && !reset && !beat_stall;
    assign rd_idx    = rd_base + {{(ADDR_WIDTH-2){1'b0}}, beat};
    assign ret_data  = ret_valid ? mem[rd_idx] : 32'h0;
    assign ret_last  = (ret_valid && beat == last_beat) ? 2'b01 : 2'b00;

    // NOTE: RAM has no reset branch; contents must survive reset and a reset port
    // on every word would block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            if (wr_type == TYPE_LINE) begin
                for (int k = 0; k < 4; k++)
                    mem[{wr_addr[ADDR_WIDTH+1:4], 2'(k)}] <= wr_data[32*k +: 32];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (wr_wstrb[b])
                        mem[wr_addr[ADDR_WIDTH+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= R_IDLE;
            w_state   <= W_IDLE;
            r_cnt     <= '0;
            w_cnt     <= '0;
            rd_base   <= '0;
            beat      <= '0;
            last_beat <= '0;
        end else begin
            r_state   <= r_next;
            w_state   <= w_next;
            r_cnt     <= r_cnt_next;
            w_cnt     <= w_cnt_next;
            rd_base   <= rd_base_next;
            beat      <= beat_next;
            last_beat <= last_beat_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        r_next         = r_state;
        r_cnt_next     = r_cnt;
        rd_base_next   = rd_base;
        beat_next      = beat;
        last_beat_next = last_beat;
        case (r_state)
            R_IDLE: begin
                if (rd_accept) begin
                    beat_next = 2'd0;
                    if (rd_type == TYPE_LINE) begin
                        rd_base_next   = {rd_addr[ADDR_WIDTH+1:4], 2'b00};
                        last_beat_next = 2'd3;
                    end else begin
                        rd_base_next   = rd_addr[ADDR_WIDTH+1:2];
                        last_beat_next = 2'd0;
                    end
                    if (RD_LATENCY <= 1) begin
                        r_next = R_DATA;
                    end else begin
                        r_next     = R_WAIT;
                        r_cnt_next = RD_CNT_INIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt == 16'd0) r_next = R_DATA;
                else                r_cnt_next = r_cnt - 16'd1;
            end
            R_DATA: begin
                if (ret_valid) begin
                    if (beat == last_beat) r_next = R_IDLE;
                    else                   beat_next = beat + 2'd1;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next     = w_state;
        w_cnt_next = w_cnt;
        case (w_state)
            W_IDLE: begin
                if (wr_accept && WR_LATENCY > 0) begin
                    w_next     = W_BUSY;
                    w_cnt_next = WR_CNT_INIT;
                end
            end
            W_BUSY: begin
                if (w_cnt == 16'd0) w_next = W_IDLE;
                else                w_cnt_next = w_cnt - 16'd1;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Address bits outside the RAM index alias and are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr[31:ADDR_WIDTH+2], rd_addr[1:0],
                                wr_addr[31:ADDR_WIDTH+2], wr_addr[1:0]};

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a default instance plus one with
// WR_LATENCY=0 / RD_LATENCY=1 to cover the latency boundaries.
module tb_cache_mem_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req, wr_req;
    logic [2:0]   rd_type, wr_type;
    logic [31:0]  rd_addr, wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         rd_rdy, ret_valid, wr_rdy;
    logic [1:0]   ret_last;
    logic [31:0]  ret_data;

    logic         z_rd_req, z_wr_req;
    logic [2:0]   z_rd_type, z_wr_type;
    logic [31:0]  z_rd_addr, z_wr_addr;
    logic [3:0]   z_wr_wstrb;
    logic [127:0] z_wr_data;
    logic         z_rd_rdy, z_ret_valid, z_wr_rdy;
    logic [1:0]   z_ret_last;
    logic [31:0]  z_ret_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cache_mem_responder dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
        .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    cache_mem_responder #(.ADDR_WIDTH(10), .RD_LATENCY(1), .WR_LATENCY(0)) dut_z (
        .clk(clk), .reset(reset),
        .rd_req(z_rd_req), .rd_type(z_rd_type), .rd_addr(z_rd_addr), .rd_rdy(z_rd_rdy),
        .ret_valid(z_ret_valid), .ret_last(z_ret_last), .ret_data(z_ret_data),
        .wr_req(z_wr_req), .wr_type(z_wr_type), .wr_addr(z_wr_addr),
        .wr_wstrb(z_wr_wstrb), .wr_data(z_wr_data), .wr_rdy(z_wr_rdy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wr_idle(input string tag);
        int n = 0;
        while (wr_rdy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(wr_rdy), 32'd1);
    endtask

    // Issue a read on the default instance (RD_LATENCY=2) and check n beats
    task automatic read_burst(input string tag, input logic [2:0] typ,
                              input logic [31:0] addr, input logic [127:0] exp, input int n);
        rd_req  = 1'b1;
        rd_type = typ;
        rd_addr = addr;
        check({tag, "_rdy"}, 32'(rd_rdy), 32'd1);
        step();
        rd_req = 1'b0;
        check({tag, "_wait"}, 32'(ret_valid), 32'd0);
        step();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_v%0d", tag, k), 32'(ret_valid), 32'd1);
            check($sformatf("%s_d%0d", tag, k), ret_data, exp[32*k +: 32]);
            check($sformatf("%s_l%0d", tag, k), 32'(ret_last), (k == n - 1) ? 32'd1 : 32'd0);
            step();
        end
        check({tag, "_end_v"}, 32'(ret_valid), 32'd0);
        check({tag, "_end_d"}, ret_data, 32'd0);
        check({tag, "_end_rdy"}, 32'(rd_rdy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rd_req = 1'b0; rd_type = 3'b010; rd_addr = '0;
        wr_req = 1'b0; wr_type = 3'b010; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        z_rd_req = 1'b0; z_rd_type = 3'b010; z_rd_addr = '0;
        z_wr_req = 1'b0; z_wr_type = 3'b010; z_wr_addr = '0; z_wr_wstrb = '0; z_wr_data = '0;

        // Reset state
        step();
        step();
        check("rst_rd_rdy", 32'(rd_rdy), 32'd0);
        check("rst_wr_rdy", 32'(wr_rdy), 32'd0);
        check("rst_ret_valid", 32'(ret_valid), 32'd0);
        check("rst_ret_last", 32'(ret_last), 32'd0);
        check("rst_ret_data", ret_data, 32'd0);
        check("rst_z_wr_rdy", 32'(z_wr_rdy), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_rd_rdy", 32'(rd_rdy), 32'd1);
        check("post_rst_wr_rdy", 32'(wr_rdy), 32'd1);

        // Line write, then wr_rdy low for exactly 3 cycles
        wr_req  = 1'b1;
        wr_type = 3'b100;
        wr_addr = 32'h1C00_0010;
        wr_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        step();
        wr_req = 1'b0;
        check("wlat_c1", 32'(wr_rdy), 32'd0);
        step();
        check("wlat_c2", 32'(wr_rdy), 32'd0);
        step();
        check("wlat_c3", 32'(wr_rdy), 32'd0);
        step();
        check("wlat_idle", 32'(wr_rdy), 32'd1);

        read_burst("line_rd", 3'b100, 32'h1C00_0018,
                   {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 4);

        // Byte-strobe merge on a word
        wr_req   = 1'b1;
        wr_type  = 3'b010;
        wr_addr  = 32'h1C00_0020;
        wr_wstrb = 4'b1111;
        wr_data  = {96'h0, 32'hAABB_CCDD};
        step();
        wr_req = 1'b0;
        wait_wr_idle("wr_idle_a");
        wr_req   = 1'b1;
        wr_wstrb = 4'b0101;
        wr_data  = {96'h0, 32'h1122_3344};
        step();
        wr_req = 1'b0;
        read_burst("strb_rd", 3'b010, 32'h1C00_0020, {96'h0, 32'hAA22_CC44}, 1);

        // Same-cycle read and write of one line
        wait_wr_idle("wr_idle_b");
        wr_req  = 1'b1;
        wr_type = 3'b100;
        wr_addr = 32'h0000_0100;
        wr_data = {4{32'h5A5A_5A5A}};
        check("same_wr_rdy", 32'(wr_rdy), 32'd1);
        read_burst("same_rd", 3'b100, 32'h0000_0100, {4{32'h5A5A_5A5A}}, 4);
        wr_req = 1'b0;

        // Aliasing: 0x1000 maps onto index 0 with ADDR_WIDTH=10
        wait_wr_idle("wr_idle_c");
        wr_req   = 1'b1;
        wr_type  = 3'b010;
        wr_addr  = 32'h0000_1000;
        wr_wstrb = 4'b1111;
        wr_data  = {96'h0, 32'hCAFE_F00D};
        step();
        wr_req = 1'b0;
        read_burst("alias_rd", 3'b000, 32'h0000_0000, {96'h0, 32'hCAFE_F00D}, 1);

        // Reset after the second beat of a line read
        rd_req  = 1'b1;
        rd_type = 3'b100;
        rd_addr = 32'h1C00_0010;
        step();
        rd_req = 1'b0;
        step();
        check("mid_b0", ret_data, 32'h1111_1111);
        step();
        check("mid_b1", ret_data, 32'h2222_2222);
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(ret_valid), 32'd0);
        check("mid_rst_rd_rdy", 32'(rd_rdy), 32'd0);
        check("mid_rst_data", ret_data, 32'd0);
        step();
        check("mid_rst_valid2", 32'(ret_valid), 32'd0);
        check("mid_rst_rd_rdy2", 32'(rd_rdy), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_post_rd_rdy", 32'(rd_rdy), 32'd1);
        step();
        step();
        check("mid_no_beats", 32'(ret_valid), 32'd0);
        read_burst("post_rst_rd", 3'b100, 32'h1C00_0010,
                   {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 4);

        // WR_LATENCY=0: back-to-back word writes, then RD_LATENCY=1 line read
        z_wr_type  = 3'b010;
        z_wr_wstrb = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            z_wr_req  = 1'b1;
            z_wr_addr = 32'(4 * i);
            z_wr_data = {96'h0, 32'hDEAD_0000 + 32'(i)};
            check($sformatf("z_wr_rdy%0d", i), 32'(z_wr_rdy), 32'd1);
            step();
        end
        z_wr_req = 1'b0;
        check("z_wr_rdy_after", 32'(z_wr_rdy), 32'd1);
        z_rd_req  = 1'b1;
        z_rd_type = 3'b100;
        z_rd_addr = 32'h0000_0000;
        check("z_rd_rdy", 32'(z_rd_rdy), 32'd1);
        step();
        z_rd_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("z_v%0d", k), 32'(z_ret_valid), 32'd1);
            check($sformatf("z_d%0d", k), z_ret_data, 32'hDEAD_0000 + 32'(k));
            check($sformatf("z_l%0d", k), 32'(z_ret_last), (k == 3) ? 32'd1 : 32'd0);
            step();
        end
        check("z_end_v", 32'(z_ret_valid), 32'd0);
        check("z_end_rdy", 32'(z_rd_rdy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
